// File: rtl/debug_unit_transmit_pkg.sv
// Shared definitions for the debug unit transmit/receive pair:
// widths, frame geometry and FSM state encodings.
`default_nettype none

package debug_unit_transmit_pkg;

   localparam int NB_DATA     = 32;
   localparam int NB_BYTE     = 8;
   localparam int NB_REGISTER = 5;
   localparam int NB_MEM_ADDR = 5;
   localparam int NB_STATE    = 3;

   localparam int REG_WORDS   = 32;
   localparam int MEM_WORDS   = 32;
   localparam int FRAME_WORDS = 2 + REG_WORDS + MEM_WORDS;

   typedef enum logic [NB_STATE-1:0] {
      ST_IDLE        = 3'd0,
      ST_SEND_PC     = 3'd1,
      ST_SEND_CYCLES = 3'd2,
      ST_SEND_REGS   = 3'd3,
      ST_SEND_MEM    = 3'd4,
      ST_DONE        = 3'd5
   } tx_state_e;

endpackage

`default_nettype wire

// File: rtl/debug_unit_word_sender.sv
// Serialises one word into UART bytes, LSB first, one tx_start/tx_done
// handshake per byte; flags the start of the last byte and word completion.
`default_nettype none

module debug_unit_word_sender #(
   parameter int NB_DATA = 32,
   parameter int NB_BYTE = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic [NB_DATA-1:0] word_i,
   input  logic               tx_done_i,
   output logic [NB_BYTE-1:0] tx_data_o,
   output logic               tx_start_o,
   output logic               last_byte_o,
   output logic               word_done_o
);

   localparam int NB_IDX = $clog2(NB_DATA / NB_BYTE);

   logic [NB_DATA-1:0] shift_q;
   logic [NB_IDX-1:0]  byte_idx_q;
   logic               busy_q;
   logic               tx_start_q;
   logic               byte_done;

   // A done arriving in the same cycle as the start pulse cannot belong to this byte.
   assign byte_done   = busy_q && !tx_start_q && tx_done_i;
   assign word_done_o = byte_done && (byte_idx_q == '1);
   assign last_byte_o = tx_start_q && (byte_idx_q == '1);
   assign tx_data_o   = shift_q[NB_BYTE-1:0];
   assign tx_start_o  = tx_start_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         shift_q    <= '0;
         byte_idx_q <= '0;
         busy_q     <= 1'b0;
         tx_start_q <= 1'b0;
      end else begin
         tx_start_q <= 1'b0;
         if (start_i) begin
            shift_q    <= word_i;
            byte_idx_q <= '0;
            busy_q     <= 1'b1;
            tx_start_q <= 1'b1;
         end else if (byte_done) begin
            if (byte_idx_q == '1) begin
               busy_q <= 1'b0;
            end else begin
               shift_q    <= shift_q >> NB_BYTE;
               byte_idx_q <= byte_idx_q + NB_IDX'(1);
               tx_start_q <= 1'b1;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/debug_unit_transmit.sv
// Dumps PC, cycle count, register file and data memory over the UART
// as a 66-word, LSB-first byte frame after each halt/step request.
`default_nettype none

module debug_unit_transmit #(
   parameter int NB_DATA     = debug_unit_transmit_pkg::NB_DATA,
   parameter int NB_BYTE     = debug_unit_transmit_pkg::NB_BYTE,
   parameter int NB_REGISTER = debug_unit_transmit_pkg::NB_REGISTER,
   parameter int NB_MEM_ADDR = debug_unit_transmit_pkg::NB_MEM_ADDR,
   parameter int NB_STATE    = debug_unit_transmit_pkg::NB_STATE
) (
   input  logic                   i_clock,
   input  logic                   i_reset,
   input  logic                   i_send_request,
   input  logic [NB_DATA-1:0]     i_pc,
   input  logic [NB_DATA-1:0]     i_cycle_count,
   input  logic [NB_DATA-1:0]     i_register_data,
   input  logic [NB_DATA-1:0]     i_memory_data,
   input  logic                   i_tx_done,
   output logic [NB_BYTE-1:0]     o_tx_data,
   output logic                   o_tx_start,
   output logic [NB_REGISTER-1:0] o_register_address,
   output logic [NB_MEM_ADDR-1:0] o_memory_address,
   output logic                   o_busy,
   output logic                   o_done,
   output logic [NB_STATE-1:0]    o_state
);

   import debug_unit_transmit_pkg::*;

   tx_state_e              state_q;
   logic [NB_DATA-1:0]     pc_q;
   logic [NB_DATA-1:0]     cycles_q;
   logic [NB_REGISTER-1:0] reg_addr_q;
   logic [NB_MEM_ADDR-1:0] mem_addr_q;
   logic                   busy_q;
   logic                   done_q;
   logic                   word_start_q;
   logic                   final_q;

   logic [NB_DATA-1:0]     word_sel;
   logic                   sender_start;
   logic                   last_byte;
   logic                   word_done;

   always_comb begin
      word_sel = i_register_data;
      case (state_q)
         ST_SEND_PC:     word_sel = pc_q;
         ST_SEND_CYCLES: word_sel = cycles_q;
         ST_SEND_MEM:    word_sel = i_memory_data;
         default:        word_sel = i_register_data;
      endcase
   end

   // Next word is chained straight off the last tx_done so the byte gap stays one cycle.
   assign sender_start = word_start_q || (word_done && !final_q);

   debug_unit_word_sender #(
      .NB_DATA (NB_DATA),
      .NB_BYTE (NB_BYTE)
   ) u_word_sender (
      .clk_i       (i_clock),
      .rst_i       (i_reset),
      .start_i     (sender_start),
      .word_i      (word_sel),
      .tx_done_i   (i_tx_done),
      .tx_data_o   (o_tx_data),
      .tx_start_o  (o_tx_start),
      .last_byte_o (last_byte),
      .word_done_o (word_done)
   );

   // State and read address advance as the last byte of a word starts, so the
   // next word's address is settled well before the sender latches it.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q      <= ST_IDLE;
         pc_q         <= '0;
         cycles_q     <= '0;
         reg_addr_q   <= '0;
         mem_addr_q   <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         word_start_q <= 1'b0;
         final_q      <= 1'b0;
      end else begin
         word_start_q <= 1'b0;
         done_q       <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (i_send_request) begin
                  state_q      <= ST_SEND_PC;
                  pc_q         <= i_pc;
                  cycles_q     <= i_cycle_count;
                  busy_q       <= 1'b1;
                  word_start_q <= 1'b1;
                  final_q      <= 1'b0;
               end
            end
            ST_SEND_PC: begin
               if (last_byte) state_q <= ST_SEND_CYCLES;
            end
            ST_SEND_CYCLES: begin
               if (last_byte) state_q <= ST_SEND_REGS;
            end
            ST_SEND_REGS: begin
               if (last_byte) begin
                  if (reg_addr_q == NB_REGISTER'(REG_WORDS - 1)) begin
                     reg_addr_q <= '0;
                     state_q    <= ST_SEND_MEM;
                  end else begin
                     reg_addr_q <= reg_addr_q + NB_REGISTER'(1);
                  end
               end
            end
            ST_SEND_MEM: begin
               if (last_byte) begin
                  if (mem_addr_q == NB_MEM_ADDR'(MEM_WORDS - 1)) begin
                     mem_addr_q <= '0;
                     final_q    <= 1'b1;
                  end else begin
                     mem_addr_q <= mem_addr_q + NB_MEM_ADDR'(1);
                  end
               end
               if (word_done && final_q) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  final_q <= 1'b0;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_register_address = reg_addr_q;
   assign o_memory_address   = mem_addr_q;
   assign o_busy             = busy_q;
   assign o_done             = done_q;
   assign o_state            = state_q;

endmodule

`default_nettype wire

// File: tb/tb_debug_unit_transmit.sv
// Directed bench for debug_unit_transmit with an auto-responding UART model
// and a combinational register/memory model.
`default_nettype none

module tb_debug_unit_transmit;

   logic        clk;
   logic        rst;
   logic        i_send_request;
   logic [31:0] i_pc;
   logic [31:0] i_cycle_count;
   logic [31:0] i_register_data;
   logic [31:0] i_memory_data;
   logic        i_tx_done;
   logic [7:0]  o_tx_data;
   logic        o_tx_start;
   logic [4:0]  o_register_address;
   logic [4:0]  o_memory_address;
   logic        o_busy;
   logic        o_done;
   logic [2:0]  o_state;

   logic        auto_done;
   logic        manual_done;
   int          lat;

   int          n_vec = 0;
   int          n_miscmp = 0;

   int          n_start = 0;
   int          n_done = 0;
   int          overlap_err = 0;
   int          stable_err = 0;
   int          busy_done_err = 0;
   logic        inflight = 1'b0;
   logic [7:0]  held = 8'h00;
   logic [7:0]  bytes_q[$];

   assign i_tx_done       = auto_done | manual_done;
   assign i_register_data = 32'h1122_3300 + {27'd0, o_register_address};
   assign i_memory_data   = 32'hA000_0000 + {27'd0, o_memory_address};

   debug_unit_transmit dut (
      .i_clock            (clk),
      .i_reset            (rst),
      .i_send_request     (i_send_request),
      .i_pc               (i_pc),
      .i_cycle_count      (i_cycle_count),
      .i_register_data    (i_register_data),
      .i_memory_data      (i_memory_data),
      .i_tx_done          (i_tx_done),
      .o_tx_data          (o_tx_data),
      .o_tx_start         (o_tx_start),
      .o_register_address (o_register_address),
      .o_memory_address   (o_memory_address),
      .o_busy             (o_busy),
      .o_done             (o_done),
      .o_state            (o_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // UART model: tx_done is returned lat cycles after each observed start.
   initial begin
      auto_done = 1'b0;
      forever begin
         @(negedge clk);
         if (o_tx_start === 1'b1) begin
            repeat (lat) @(posedge clk);
            #1 auto_done = 1'b1;
            @(posedge clk);
            #1 auto_done = 1'b0;
         end
      end
   end

   // Byte capture plus in-flight, hold-stability and done/busy bookkeeping.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            inflight = 1'b0;
         end else begin
            if (o_tx_start) begin
               if (inflight) overlap_err++;
               inflight = 1'b1;
               held     = o_tx_data;
               bytes_q.push_back(o_tx_data);
               n_start++;
            end else begin
               if (inflight && o_tx_data !== held) stable_err++;
               if (inflight && i_tx_done) inflight = 1'b0;
            end
            if (o_done) begin
               n_done++;
               if (o_busy) busy_done_err++;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miscmp++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic start_dump(input logic [31:0] pc, input logic [31:0] cyc, input string tag);
      i_pc           = pc;
      i_cycle_count  = cyc;
      i_send_request = 1'b1;
      @(negedge clk);
      i_send_request = 1'b0;
      i_pc           = 32'hDEAD_BEEF;
      i_cycle_count  = 32'hFFFF_FFFF;
      check({tag, "_busy_on_accept"}, {31'd0, o_busy}, 32'd1);
      check({tag, "_state_send_pc"}, {29'd0, o_state}, 32'd1);
      check({tag, "_no_start_yet"}, {31'd0, o_tx_start}, 32'd0);
      @(negedge clk);
      check({tag, "_first_start"}, {31'd0, o_tx_start}, 32'd1);
      check({tag, "_first_byte"}, {24'd0, o_tx_data}, {24'd0, pc[7:0]});
   endtask

   task automatic run_to_done(input int budget, input int poke_at, output int cycles);
      cycles = 0;
      while (o_done !== 1'b1 && cycles < budget) begin
         i_send_request = (cycles == poke_at);
         @(negedge clk);
         cycles++;
      end
      i_send_request = 1'b0;
      check("done_seen", {31'd0, o_done}, 32'd1);
   endtask

   initial begin
      int base;
      int cyc;
      int ns;
      int nd;

      rst            = 1'b1;
      i_send_request = 1'b0;
      i_pc           = 32'd0;
      i_cycle_count  = 32'd0;
      manual_done    = 1'b0;
      lat            = 3;
      repeat (3) @(negedge clk);
      check("rst_state", {29'd0, o_state}, 32'd0);
      check("rst_tx_start", {31'd0, o_tx_start}, 32'd0);
      check("rst_tx_data", {24'd0, o_tx_data}, 32'd0);
      check("rst_busy", {31'd0, o_busy}, 32'd0);
      check("rst_done", {31'd0, o_done}, 32'd0);
      check("rst_reg_addr", {27'd0, o_register_address}, 32'd0);
      check("rst_mem_addr", {27'd0, o_memory_address}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Spurious tx_done in IDLE
      manual_done = 1'b1;
      @(negedge clk);
      manual_done = 1'b0;
      repeat (3) @(negedge clk);
      check("spurious_no_start", n_start, 32'd0);
      check("spurious_tx_data", {24'd0, o_tx_data}, 32'd0);
      check("spurious_state", {29'd0, o_state}, 32'd0);

      // Dump 1: latency 3, mid-dump request, request coincident with o_done
      base = bytes_q.size();
      nd   = n_done;
      start_dump(32'h0000_0040, 32'h0000_000A, "d1");
      run_to_done(2000, 300, cyc);
      check("d1_cycles", cyc, 32'd1056);
      check("d1_busy_at_done", {31'd0, o_busy}, 32'd0);
      i_send_request = 1'b1;
      @(negedge clk);
      i_send_request = 1'b0;
      check("d1_req_at_done_state", {29'd0, o_state}, 32'd0);
      check("d1_req_at_done_busy", {31'd0, o_busy}, 32'd0);
      repeat (20) @(negedge clk);
      check("d1_still_idle", {29'd0, o_state}, 32'd0);
      check("d1_byte_count", bytes_q.size() - base, 32'd264);
      check("d1_done_count", n_done - nd, 32'd1);
      check("d1_b0", {24'd0, bytes_q[base + 0]}, 32'h40);
      check("d1_b1", {24'd0, bytes_q[base + 1]}, 32'h00);
      check("d1_b2", {24'd0, bytes_q[base + 2]}, 32'h00);
      check("d1_b3", {24'd0, bytes_q[base + 3]}, 32'h00);
      check("d1_b4", {24'd0, bytes_q[base + 4]}, 32'h0A);
      check("d1_b5", {24'd0, bytes_q[base + 5]}, 32'h00);
      check("d1_b7", {24'd0, bytes_q[base + 7]}, 32'h00);
      check("d1_b8_reg0", {24'd0, bytes_q[base + 8]}, 32'h00);
      check("d1_b9_reg0", {24'd0, bytes_q[base + 9]}, 32'h33);
      check("d1_b11_reg0", {24'd0, bytes_q[base + 11]}, 32'h11);
      check("d1_b28_reg5", {24'd0, bytes_q[base + 28]}, 32'h05);
      check("d1_b135_reg31", {24'd0, bytes_q[base + 135]}, 32'h11);
      check("d1_b136_mem0", {24'd0, bytes_q[base + 136]}, 32'h00);
      check("d1_b139_mem0", {24'd0, bytes_q[base + 139]}, 32'hA0);
      check("d1_b140_mem1", {24'd0, bytes_q[base + 140]}, 32'h01);
      check("d1_b260_mem31", {24'd0, bytes_q[base + 260]}, 32'h1F);
      check("d1_b263_last", {24'd0, bytes_q[base + 263]}, 32'hA0);
      check("d1_reg_addr_wrap", {27'd0, o_register_address}, 32'd0);
      check("d1_mem_addr_wrap", {27'd0, o_memory_address}, 32'd0);

      // Dump 2: latency 1
      lat  = 1;
      base = bytes_q.size();
      start_dump(32'h1234_5678, 32'h9ABC_DEF0, "d2");
      run_to_done(2000, -1, cyc);
      check("d2_cycles", cyc, 32'd528);
      repeat (10) @(negedge clk);
      check("d2_byte_count", bytes_q.size() - base, 32'd264);
      check("d2_b1", {24'd0, bytes_q[base + 1]}, 32'h56);
      check("d2_b3", {24'd0, bytes_q[base + 3]}, 32'h12);
      check("d2_b4", {24'd0, bytes_q[base + 4]}, 32'hF0);
      check("d2_b7", {24'd0, bytes_q[base + 7]}, 32'h9A);
      check("d2_b263_last", {24'd0, bytes_q[base + 263]}, 32'hA0);

      // Dump 3: reset after byte 20, then restart
      lat  = 3;
      base = bytes_q.size();
      start_dump(32'h0000_0040, 32'h0000_000A, "d3");
      cyc = 0;
      while ((bytes_q.size() - base) < 21 && cyc < 500) begin
         @(negedge clk);
         cyc++;
      end
      check("d3_reached_byte20", {31'd0, (bytes_q.size() - base) >= 21}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      ns = n_start;
      check("d3_rst_tx_start", {31'd0, o_tx_start}, 32'd0);
      check("d3_rst_busy", {31'd0, o_busy}, 32'd0);
      check("d3_rst_state", {29'd0, o_state}, 32'd0);
      check("d3_rst_reg_addr", {27'd0, o_register_address}, 32'd0);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check("d3_no_start_after_rst", n_start, ns);
      base = bytes_q.size();
      start_dump(32'h0000_0123, 32'h0000_0005, "d3r");
      run_to_done(2000, -1, cyc);
      check("d3r_cycles", cyc, 32'd1056);
      repeat (10) @(negedge clk);
      check("d3r_byte_count", bytes_q.size() - base, 32'd264);
      check("d3r_b4", {24'd0, bytes_q[base + 4]}, 32'h05);

      check("overlap_errors", overlap_err, 32'd0);
      check("hold_errors", stable_err, 32'd0);
      check("busy_with_done", busy_done_err, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end

endmodule

`default_nettype wire
